// File: rtl/i2c_pkg.sv
// Shared state encoding, protocol constants and timing defaults for the I2C target responder.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR       = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD       = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int BYTE_BITS   = 8;
  localparam int ACK_BIT_IDX = 8;

  localparam int SYS_CLK_MHZ = 20;
  localparam int HOLD_NS     = 500;

  function automatic int hold_cycles(input int clk_mhz, input int hold_ns);
    return (clk_mhz * hold_ns) / 1000;
  endfunction

  localparam int DEFAULT_HOLD_CYCLES = hold_cycles(SYS_CLK_MHZ, HOLD_NS);

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample deglitch for one open-drain line,
// with single-cycle rise/fall pulses of the filtered level.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic sys_clock,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0]            r_sync;
  logic [FILTER_LEN-1:0] r_samp;
  logic                  r_level;
  logic                  r_level_prev;

  // Idle bus level is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_sync       <= '1;
      r_samp       <= '1;
      r_level      <= 1'b1;
      r_level_prev <= 1'b1;
    end else begin
      r_sync       <= {r_sync[0], i_line};
      r_samp       <= {r_samp[FILTER_LEN-2:0], r_sync[1]};
      if (&r_samp)
        r_level <= 1'b1;
      else if (~|r_samp)
        r_level <= 1'b0;
      r_level_prev <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_prev;
  assign o_fall  = ~r_level & r_level_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target responder: exposes an 8-bit register space with pointer write,
// burst write and burst read (auto-increment). SDA is only ever pulled low.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | acking our address; read fetch issued on 8th fall
// PTR/_ACK  | receiving register pointer / acking it
// WR/_ACK   | receiving write data / acking it
// RD/_ACK   | shifting out read data / sampling controller ACK
// IGNORE    | not addressed or NACKed; wait for START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h52,
  parameter int         FILTER_LEN  = 4,
  parameter int         HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .sys_clock (sys_clock),
    .reset     (reset),
    .i_line    (scl_in),
    .o_level   (w_scl),
    .o_rise    (w_scl_rise),
    .o_fall    (w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .sys_clock (sys_clock),
    .reset     (reset),
    .i_line    (sda_in),
    .o_level   (w_sda),
    .o_rise    (w_sda_rise),
    .o_fall    (w_sda_fall)
  );

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_tx, w_tx_nxt;
  logic          r_rw, w_rw_nxt;
  logic          r_ack_ph, w_ack_ph_nxt;
  logic [7:0]    r_reg_addr, w_addr_nxt;
  logic [7:0]    r_reg_wdata, w_wdata_nxt;
  logic          r_reg_we, w_we_nxt;
  logic          r_reg_re, w_re_nxt;
  logic          r_re_pend, w_re_pend_nxt;
  logic          r_load_tx, w_load_tx_nxt;
  logic          r_inc_pend, w_inc_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_sda_low, w_sda_low_nxt;
  logic [HW-1:0] r_hold_cnt, w_hold_nxt;
  logic          r_pend_vld, w_pend_vld_nxt;
  logic          r_pend_val, w_pend_val_nxt;
  logic [7:0]    w_byte;
  logic          w_sched;
  logic          w_sched_val;

  always_comb begin
    w_byte         = {r_shift[6:0], w_sda};
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_rw_nxt       = r_rw;
    w_ack_ph_nxt   = r_ack_ph;
    w_addr_nxt     = r_reg_addr;
    w_wdata_nxt    = r_reg_wdata;
    w_we_nxt       = 1'b0;
    w_re_nxt       = r_re_pend;
    w_re_pend_nxt  = 1'b0;
    w_load_tx_nxt  = r_reg_re;
    w_inc_nxt      = 1'b0;
    w_busy_nxt     = r_busy;
    w_sda_low_nxt  = r_sda_low;
    w_hold_nxt     = r_hold_cnt;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_val_nxt = r_pend_val;
    w_sched        = 1'b0;
    w_sched_val    = 1'b0;

    if (r_inc_pend)
      w_addr_nxt = r_reg_addr + 8'd1;
    if (r_load_tx)
      w_tx_nxt = reg_rdata;

    // SDA updates are deferred by a down-counter so they land well inside SCL low.
    if (r_pend_vld) begin
      if (r_hold_cnt <= HW'(1)) begin
        w_sda_low_nxt  = r_pend_val;
        w_pend_vld_nxt = 1'b0;
      end else begin
        w_hold_nxt = r_hold_cnt - HW'(1);
      end
    end

    if (w_sda_fall && w_scl) begin
      w_state_nxt    = ST_ADDR;
      w_bit_cnt_nxt  = 4'd0;
      w_ack_ph_nxt   = 1'b0;
      w_busy_nxt     = 1'b0;
      w_sda_low_nxt  = 1'b0;
      w_pend_vld_nxt = 1'b0;
    end else if (w_sda_rise && w_scl) begin
      w_state_nxt    = ST_IDLE;
      w_busy_nxt     = 1'b0;
      w_sda_low_nxt  = 1'b0;
      w_pend_vld_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'(BYTE_BITS - 1)) begin
            if (w_byte[7:1] == TARGET_ADDR) begin
              w_state_nxt  = ST_ADDR_ACK;
              w_busy_nxt   = 1'b1;
              w_rw_nxt     = w_byte[0];
              w_ack_ph_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: if (w_scl_fall) begin
          w_sched = 1'b1;
          if (!r_ack_ph) begin
            w_sched_val  = ~ACK;
            w_ack_ph_nxt = 1'b1;
            w_re_nxt     = r_rw;
          end else begin
            w_ack_ph_nxt  = 1'b0;
            w_bit_cnt_nxt = 4'd0;
            w_sched_val   = r_rw ? ~r_tx[7] : 1'b0;
            w_state_nxt   = r_rw ? ST_RD : ST_PTR;
          end
        end
        ST_PTR, ST_WR: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'(BYTE_BITS - 1)) begin
            w_ack_ph_nxt = 1'b0;
            if (r_state == ST_PTR) begin
              w_addr_nxt  = w_byte;
              w_state_nxt = ST_PTR_ACK;
            end else begin
              w_wdata_nxt = w_byte;
              w_we_nxt    = 1'b1;
              w_inc_nxt   = 1'b1;
              w_state_nxt = ST_WR_ACK;
            end
          end
        end
        ST_PTR_ACK, ST_WR_ACK: if (w_scl_fall) begin
          w_sched = 1'b1;
          if (!r_ack_ph) begin
            w_sched_val  = ~ACK;
            w_ack_ph_nxt = 1'b1;
          end else begin
            w_ack_ph_nxt  = 1'b0;
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = ST_WR;
          end
        end
        ST_RD: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            w_sched = 1'b1;
            if (r_bit_cnt == 4'(ACK_BIT_IDX)) begin
              w_ack_ph_nxt = 1'b0;
              w_state_nxt  = ST_RD_ACK;
            end else begin
              w_tx_nxt    = {r_tx[6:0], 1'b0};
              w_sched_val = ~r_tx[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == NACK) begin
              w_state_nxt = ST_IGNORE;
            end else begin
              w_addr_nxt    = r_reg_addr + 8'd1;
              w_re_pend_nxt = 1'b1;
              w_ack_ph_nxt  = 1'b1;
            end
          end else if (w_scl_fall && r_ack_ph) begin
            w_sched       = 1'b1;
            w_sched_val   = ~r_tx[7];
            w_ack_ph_nxt  = 1'b0;
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = ST_RD;
          end
        end
        default: ;
      endcase
    end

    if (w_sched) begin
      w_hold_nxt     = HW'(HOLD_CYCLES);
      w_pend_vld_nxt = 1'b1;
      w_pend_val_nxt = w_sched_val;
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_tx        <= 8'd0;
      r_rw        <= 1'b0;
      r_ack_ph    <= 1'b0;
      r_reg_addr  <= 8'd0;
      r_reg_wdata <= 8'd0;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
      r_re_pend   <= 1'b0;
      r_load_tx   <= 1'b0;
      r_inc_pend  <= 1'b0;
      r_busy      <= 1'b0;
      r_sda_low   <= 1'b0;
      r_hold_cnt  <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_val  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_tx        <= w_tx_nxt;
      r_rw        <= w_rw_nxt;
      r_ack_ph    <= w_ack_ph_nxt;
      r_reg_addr  <= w_addr_nxt;
      r_reg_wdata <= w_wdata_nxt;
      r_reg_we    <= w_we_nxt;
      r_reg_re    <= w_re_nxt;
      r_re_pend   <= w_re_pend_nxt;
      r_load_tx   <= w_load_tx_nxt;
      r_inc_pend  <= w_inc_nxt;
      r_busy      <= w_busy_nxt;
      r_sda_low   <= w_sda_low_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_val  <= w_pend_val_nxt;
    end
  end

  assign sda_drive_low = r_sda_low;
  assign reg_addr      = r_reg_addr;
  assign reg_wdata     = r_reg_wdata;
  assign reg_we        = r_reg_we;
  assign reg_re        = r_reg_re;
  assign busy          = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C controller, registered read-data
// model (addr ^ 8'hFF), and a write scoreboard checked by a bus monitor.
module tb_i2c_target;
  import i2c_pkg::*;

  logic       sys_clock = 1'b0;
  logic       reset;
  logic       scl_in;
  logic       sda_ctrl_low;
  logic       sda_in;
  logic       sda_drive_low;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_re     = 0;
  logic saw_sda_low, saw_busy, saw_strobe;
  logic [15:0] we_q[$];
  logic [7:0]  rd_q[$];

  assign sda_in = ~(sda_ctrl_low | sda_drive_low);

  always #5 sys_clock = ~sys_clock;

  i2c_target dut (
    .sys_clock     (sys_clock),
    .reset         (reset),
    .scl_in        (scl_in),
    .sda_in        (sda_in),
    .sda_drive_low (sda_drive_low),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_rdata     (reg_rdata),
    .busy          (busy)
  );

  always @(posedge sys_clock)
    if (reg_re) reg_rdata <= reg_addr ^ 8'hFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge sys_clock) begin
    if (!reset) begin
      if (reg_we) begin
        check("we_expected", 32'(we_q.size() != 0), 32'd1);
        if (we_q.size() != 0) begin
          logic [15:0] e;
          e = we_q.pop_front();
          check("we_addr", 32'(reg_addr), 32'(e[15:8]));
          check("we_data", 32'(reg_wdata), 32'(e[7:0]));
        end
      end
      if (reg_re) n_re++;
      if (sda_drive_low) saw_sda_low = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (reg_we || reg_re) saw_strobe = 1'b1;
    end
  end

  initial begin
    repeat (90000) @(posedge sys_clock);
    $display("FAIL watchdog: observed no end of test, expected finish before 90000 cycles");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  task automatic i2c_start();
    sda_ctrl_low = 1'b0; cyc(20);
    scl_in = 1'b1;       cyc(40);
    sda_ctrl_low = 1'b1; cyc(40);
    scl_in = 1'b0;       cyc(20);
  endtask

  task automatic i2c_stop();
    sda_ctrl_low = 1'b1; cyc(20);
    scl_in = 1'b1;       cyc(40);
    sda_ctrl_low = 1'b0; cyc(40);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    sda_ctrl_low = ~b; cyc(20);
    scl_in = 1'b1;
    if (glitch) begin
      cyc(15); scl_in = 1'b0; cyc(2); scl_in = 1'b1; cyc(23);
    end else begin
      cyc(40);
    end
    scl_in = 1'b0; cyc(20);
  endtask

  task automatic read_bit(output logic b);
    sda_ctrl_low = 1'b0; cyc(20);
    scl_in = 1'b1;       cyc(20);
    b = sda_in;          cyc(20);
    scl_in = 1'b0;       cyc(20);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_send, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_send, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         re0;

    reset = 1'b1; scl_in = 1'b1; sda_ctrl_low = 1'b0;
    cyc(5);
    check("rst_sda", 32'(sda_drive_low), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_re", 32'(reg_re), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    reset = 1'b0; cyc(20);

    // burst write A4 10 5A 33
    we_q.push_back({8'h10, 8'h5A});
    we_q.push_back({8'h11, 8'h33});
    i2c_start();
    write_byte(8'hA4, -1, ack); check("s1_ack_addr", 32'(ack), 32'(ACK));
    check("s1_busy", 32'(busy), 32'd1);
    write_byte(8'h10, -1, ack); check("s1_ack_ptr", 32'(ack), 32'(ACK));
    write_byte(8'h5A, -1, ack); check("s1_ack_d0", 32'(ack), 32'(ACK));
    write_byte(8'h33, -1, ack); check("s1_ack_d1", 32'(ack), 32'(ACK));
    i2c_stop(); cyc(20);
    check("s1_we_left", 32'(we_q.size()), 32'd0);
    check("s1_addr_end", 32'(reg_addr), 32'h12);
    check("s1_busy_stop", 32'(busy), 32'd0);

    // pointer write, STOP, then burst read ACK + NACK
    i2c_start();
    write_byte(8'hA4, -1, ack); check("s2_ack_addr", 32'(ack), 32'(ACK));
    write_byte(8'h20, -1, ack); check("s2_ack_ptr", 32'(ack), 32'(ACK));
    i2c_stop(); cyc(20);
    re0 = n_re;
    rd_q.push_back(8'hDF);
    rd_q.push_back(8'hDE);
    i2c_start();
    write_byte(8'hA5, -1, ack); check("s2_ack_rd", 32'(ack), 32'(ACK));
    read_byte(1'b0, d); check("s2_rd0", 32'(d), 32'(rd_q.pop_front()));
    read_byte(1'b1, d); check("s2_rd1", 32'(d), 32'(rd_q.pop_front()));
    i2c_stop(); cyc(20);
    check("s2_re_count", 32'(n_re - re0), 32'd2);
    check("s2_addr_end", 32'(reg_addr), 32'h21);

    // foreign address 0x53 must be completely ignored
    saw_sda_low = 1'b0; saw_busy = 1'b0; saw_strobe = 1'b0;
    i2c_start();
    write_byte(8'hA6, -1, ack); check("s3_nack", 32'(ack), 32'(NACK));
    write_byte(8'h00, -1, ack);
    write_byte(8'h55, -1, ack);
    i2c_stop(); cyc(20);
    check("s3_sda_quiet", 32'(saw_sda_low), 32'd0);
    check("s3_busy_quiet", 32'(saw_busy), 32'd0);
    check("s3_no_strobe", 32'(saw_strobe), 32'd0);
    check("s3_addr_kept", 32'(reg_addr), 32'h21);

    // pointer wrap FF -> 00
    we_q.push_back({8'hFF, 8'h11});
    we_q.push_back({8'h00, 8'h22});
    i2c_start();
    write_byte(8'hA4, -1, ack);
    write_byte(8'hFF, -1, ack);
    write_byte(8'h11, -1, ack);
    write_byte(8'h22, -1, ack); check("s4_ack_last", 32'(ack), 32'(ACK));
    i2c_stop(); cyc(20);
    check("s4_we_left", 32'(we_q.size()), 32'd0);
    check("s4_addr_end", 32'(reg_addr), 32'h01);

    // repeated START between pointer write and read
    re0 = n_re;
    rd_q.push_back(8'hCF);
    i2c_start();
    write_byte(8'hA4, -1, ack);
    write_byte(8'h30, -1, ack); check("s5_ack_ptr", 32'(ack), 32'(ACK));
    i2c_start();
    write_byte(8'hA5, -1, ack); check("s5_ack_rd", 32'(ack), 32'(ACK));
    read_byte(1'b1, d); check("s5_rd", 32'(d), 32'(rd_q.pop_front()));
    i2c_stop(); cyc(20);
    check("s5_re_count", 32'(n_re - re0), 32'd1);
    check("s5_addr_end", 32'(reg_addr), 32'h30);

    // 2-cycle SCL low glitch while SCL is high must not add a bit
    we_q.push_back({8'h40, 8'h77});
    i2c_start();
    write_byte(8'hA4, -1, ack);
    write_byte(8'h40, 4, ack); check("s6_ack_ptr", 32'(ack), 32'(ACK));
    write_byte(8'h77, 2, ack); check("s6_ack_data", 32'(ack), 32'(ACK));
    i2c_stop(); cyc(20);
    check("s6_we_left", 32'(we_q.size()), 32'd0);
    check("s6_addr_end", 32'(reg_addr), 32'h41);

    // reset while RD drives a 0 bit (rdata 0x7F from pointer 0x80)
    i2c_start();
    write_byte(8'hA4, -1, ack);
    write_byte(8'h80, -1, ack);
    i2c_stop(); cyc(20);
    i2c_start();
    write_byte(8'hA5, -1, ack); check("s7_ack_rd", 32'(ack), 32'(ACK));
    cyc(10);
    check("s7_drive_low", 32'(sda_drive_low), 32'd1);
    check("s7_state_rd", 32'(dut.r_state), 32'(ST_RD));
    reset = 1'b1; #1;
    check("s7_sda_released", 32'(sda_drive_low), 32'd0);
    check("s7_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    cyc(3);
    check("s7_re_clr", 32'(reg_re), 32'd0);
    check("s7_busy_clr", 32'(busy), 32'd0);
    check("s7_addr_clr", 32'(reg_addr), 32'd0);
    reset = 1'b0;
    sda_ctrl_low = 1'b0; cyc(10);
    scl_in = 1'b1; cyc(40);

    // recovery after reset
    we_q.push_back({8'h05, 8'h66});
    i2c_start();
    write_byte(8'hA4, -1, ack); check("s8_ack_addr", 32'(ack), 32'(ACK));
    write_byte(8'h05, -1, ack);
    write_byte(8'h66, -1, ack);
    i2c_stop(); cyc(20);
    check("s8_we_left", 32'(we_q.size()), 32'd0);
    check("s8_addr_end", 32'(reg_addr), 32'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
